// File: rtl/csi_pkg.sv
// Shared definitions for the CSI packet parser: data-type codes, header byte
// offsets and the parser FSM state encoding.
package csi_pkg;

  localparam logic [5:0] DT_FS       = 6'h00;
  localparam logic [5:0] DT_FE       = 6'h01;
  localparam logic [5:0] DT_LS       = 6'h02;
  localparam logic [5:0] DT_LE       = 6'h03;
  localparam logic [5:0] DT_LONG_MIN = 6'h10;

  localparam int HDR_DI    = 0;
  localparam int HDR_WC_LO = 1;
  localparam int HDR_WC_HI = 2;
  localparam int HDR_ECC   = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2,
    FOOTER  = 2'd3
  } state_t;

  function automatic logic [7:0] hdr_byte(input logic [31:0] hdr, input int idx);
    return hdr[8*idx +: 8];
  endfunction

endpackage

// File: rtl/csi_hdr_collect.sv
// Assembles the 4-byte packet header from 4/LANES consecutive words; the
// assembled header and done flag are valid combinationally on the final word.
module csi_hdr_collect
  import csi_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic [8*LANES-1:0]   word,
  output logic [31:0]          hdr,
  output logic                 done
);

  localparam int WORDS = 4 / LANES;

  logic [31:0] hdr_r;
  logic [1:0]  idx_r;

  // merge the current word into the partially collected header
  always_comb begin
    hdr = hdr_r;
    for (int k = 0; k < LANES; k++) begin
      hdr[8*(int'(idx_r)*LANES + k) +: 8] = word[8*k +: 8];
    end
    done = en && (idx_r == 2'(WORDS - 1));
  end

  // word index and partial header storage
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx_r <= 2'd0;
      hdr_r <= 32'd0;
    end else if (clr) begin
      idx_r <= 2'd0;
    end else if (en) begin
      hdr_r <= hdr;
      idx_r <= done ? 2'd0 : idx_r + 2'd1;
    end
  end

endmodule

// File: rtl/csi_pkt_parser.sv
// CSI-2 style packet parser: decodes short/long packet headers, forwards
// long-packet payload of the selected virtual channel with byte enables.
module csi_pkt_parser
  import csi_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int VC_SEL = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [8*LANES-1:0] din,
  input  logic               din_valid,
  output logic [8*LANES-1:0] dout,
  output logic [LANES-1:0]   dout_be,
  output logic               dout_valid,
  output logic               fr_active,
  output logic               fr_valid,
  output logic [5:0]         pkt_dt,
  output logic [15:0]        line_count,
  output logic               err_trunc
);

  localparam logic [16:0] LANE_CNT = 17'(LANES);
  localparam logic [16:0] LAST_CNT = 17'(LANES + 2);

  state_t              state_r, state_s;
  logic [16:0]         cnt_r, cnt_s;
  logic                acc_r, acc_s;
  logic                hdr_en_s, hdr_clr_s, hdr_done_s, decode_s;
  logic [31:0]         hdr_s;
  logic [5:0]          dt_s;
  logic [1:0]          vc_s;
  logic [15:0]         wc_s;
  logic                ecc_unused_s;
  logic [8*LANES-1:0]  dout_s;
  logic [LANES-1:0]    be_s;
  logic                dv_s, fr_active_s, err_s;
  logic [5:0]          pkt_dt_s;
  logic [15:0]         line_count_s;

  csi_hdr_collect #(.LANES(LANES)) u_hdr (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (hdr_clr_s),
    .en      (hdr_en_s),
    .word    (din),
    .hdr     (hdr_s),
    .done    (hdr_done_s)
  );

  assign dt_s         = hdr_byte(hdr_s, HDR_DI)[5:0];
  assign vc_s         = hdr_byte(hdr_s, HDR_DI)[7:6];
  assign wc_s         = {hdr_byte(hdr_s, HDR_WC_HI), hdr_byte(hdr_s, HDR_WC_LO)};
  // ECC is carried but never checked
  assign ecc_unused_s = ^hdr_byte(hdr_s, HDR_ECC);

  // next-state, byte counter and registered-output next values
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    acc_s        = acc_r;
    hdr_en_s     = 1'b0;
    hdr_clr_s    = 1'b0;
    decode_s     = 1'b0;
    dout_s       = '0;
    be_s         = '0;
    dv_s         = 1'b0;
    err_s        = 1'b0;
    fr_active_s  = fr_active;
    pkt_dt_s     = pkt_dt;
    line_count_s = line_count;
    case (state_r)
      IDLE, HDR: begin
        if (din_valid) begin
          hdr_en_s = 1'b1;
          if (hdr_done_s) decode_s = 1'b1;
          else            state_s  = HDR;
        end else if (state_r == HDR) begin
          err_s     = 1'b1;
          hdr_clr_s = 1'b1;
          state_s   = IDLE;
        end else begin
          state_s = IDLE;
        end
      end
      PAYLOAD: begin
        if (din_valid) begin
          if (acc_r) begin
            dv_s   = 1'b1;
            dout_s = din;
            for (int k = 0; k < LANES; k++) begin
              be_s[k] = (cnt_r > 17'(k + 2));
            end
            if (cnt_r <= LAST_CNT) line_count_s = line_count + 16'd1;
            else                   line_count_s = line_count;
          end else begin
            dv_s = 1'b0;
          end
          if (cnt_r <= LANE_CNT) begin
            state_s = IDLE;
            cnt_s   = 17'd0;
          end else begin
            cnt_s   = cnt_r - LANE_CNT;
            state_s = ((cnt_r - LANE_CNT) <= 17'd2) ? FOOTER : PAYLOAD;
          end
        end else begin
          err_s   = 1'b1;
          state_s = IDLE;
          cnt_s   = 17'd0;
        end
      end
      FOOTER: begin
        if (din_valid) begin
          if (cnt_r <= LANE_CNT) begin
            state_s = IDLE;
            cnt_s   = 17'd0;
          end else begin
            cnt_s = cnt_r - LANE_CNT;
          end
        end else begin
          err_s   = 1'b1;
          state_s = IDLE;
          cnt_s   = 17'd0;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 17'd0;
      end
    endcase

    if (decode_s) begin
      if (dt_s < DT_LONG_MIN) begin
        state_s = IDLE;
        if (dt_s == DT_FS) begin
          fr_active_s  = 1'b1;
          line_count_s = 16'd0;
        end else if (dt_s == DT_FE) begin
          fr_active_s = 1'b0;
        end else begin
          fr_active_s = fr_active;
        end
      end else begin
        acc_s = (vc_s == 2'(VC_SEL));
        cnt_s = {1'b0, wc_s} + 17'd2;
        if (acc_s) pkt_dt_s = dt_s;
        else       pkt_dt_s = pkt_dt;
        if (wc_s == 16'd0) begin
          state_s = FOOTER;
          if (acc_s) line_count_s = line_count + 16'd1;
          else       line_count_s = line_count;
        end else begin
          state_s = PAYLOAD;
        end
      end
    end else begin
      acc_s = acc_s;
    end
  end

  // state, counter and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      cnt_r      <= 17'd0;
      acc_r      <= 1'b0;
      dout       <= '0;
      dout_be    <= '0;
      dout_valid <= 1'b0;
      fr_active  <= 1'b0;
      fr_valid   <= 1'b0;
      pkt_dt     <= 6'd0;
      line_count <= 16'd0;
      err_trunc  <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      acc_r      <= acc_s;
      dout       <= dout_s;
      dout_be    <= be_s;
      dout_valid <= dv_s;
      fr_active  <= fr_active_s;
      fr_valid   <= dv_s;
      pkt_dt     <= pkt_dt_s;
      line_count <= line_count_s;
      err_trunc  <= err_s;
    end
  end

endmodule

// File: doc/csi_pkt_parser.md
CSI_PKT_PARSER -- requirements
Module: csi_pkt_parser

Interface
REQ-001 LANES, 2, bytes per input word; legal values 1, 2, 4.
REQ-002 VC_SEL, 0, virtual channel accepted for payload output (0-3).
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 din  in  8*LANES  aligned bytes; byte k in din[8k+7:8k], byte 0 earliest on the wire.
REQ-006 din_valid  in  1  din holds a valid word this cycle.
REQ-007 dout  out  8*LANES  payload bytes, same byte order as din.
REQ-008 dout_be  out  LANES  byte enables for dout.
REQ-009 dout_valid  out  1  dout/dout_be valid this cycle.
REQ-010 fr_active  out  1  high from Frame Start to Frame End.
REQ-011 fr_valid  out  1  high on cycles carrying accepted long-packet payload.
REQ-012 pkt_dt  out  6  data type of last accepted long packet.
REQ-013 line_count  out  16  accepted long packets since last Frame Start.
REQ-014 err_trunc  out  1  one-cycle pulse on packet truncation.

Function
REQ-015 Header SHALL be 4 bytes: DI (VC=DI[7:6], DT=DI[5:0]), WC low, WC high, ECC; it SHALL span 4/LANES words, word-aligned.
REQ-016 FSM states SHALL be IDLE, HDR, PAYLOAD, FOOTER.
REQ-017 IDLE->HDR (or directly to decode when LANES=4) on first din_valid word; HDR collects remaining header words.
REQ-018 DT<0x10 is a short packet: DT 0x00 sets fr_active=1 and clears line_count; DT 0x01 clears fr_active and fr_valid; other short DTs are ignored; FSM returns to IDLE.
REQ-019 DT>=0x10 is a long packet of WC payload bytes plus 2 CRC bytes; FSM enters PAYLOAD (FOOTER directly if WC=0).
REQ-020 Byte counter SHALL be 17 bits, loaded with WC+2 at decode, decremented by LANES per accepted word.
REQ-021 In PAYLOAD each word SHALL produce dout_valid=1 only when VC==VC_SEL, with dout_be bit k set iff byte k lies within the first WC payload bytes.
REQ-022 CRC bytes and trailing filler bytes in a packet's last word SHALL be discarded; CRC is not checked.
REQ-023 When the remaining count is <=LANES, the packet SHALL end on that word; FOOTER is entered only when CRC bytes spill into a further word.
REQ-024 The word after a packet's last word SHALL be treated as the next header word (back-to-back packets allowed).
REQ-025 Accepted long packet: pkt_dt updated at decode, line_count incremented (wrapping at 0xFFFF) on its last payload word.
REQ-026 fr_valid SHALL equal dout_valid for long-packet payload.
REQ-027 din_valid=0 in HDR, PAYLOAD or FOOTER SHALL pulse err_trunc, force fr_valid=0, return FSM to IDLE; din_valid=0 in IDLE is not an error.
REQ-028 All outputs SHALL be registered; latency din -> dout is exactly 1 cycle.

Reset
REQ-029 reset_n=0 at a clock edge SHALL set FSM=IDLE, counter=0 and every output to 0, including mid-packet; no partial packet resumes.

Structure
REQ-030 Shared package csi_pkg SHALL hold DT constants (FS=0x00, FE=0x01, LS=0x02, LE=0x03, LONG_MIN=0x10), header byte offsets, and the FSM state enum.
REQ-031 One sub-module csi_hdr_collect SHALL assemble the 32-bit header from 4/LANES words and flag header-complete.

Verification (LANES=2, VC_SEL=0)
REQ-032 FS: words 0x0100, 0xEE00 -> fr_active=1 one cycle after second word; line_count=0.
REQ-033 RAW8 WC=4: 0x042A, 0xEE00, 0xBBAA, 0xDDCC, 0x5A5A -> dout 0xBBAA, 0xDDCC, be=2'b11, fr_valid high 2 cycles, line_count=1, pkt_dt=0x2A.
REQ-034 WC=3: 0x032A, 0xEE00, 0xBBAA, 0xC1CC, 0x00C2 -> second dout be=2'b01, third word consumed (FOOTER) with no output; next word decoded as header.
REQ-035 VC=1: 0x046A, 0xEE00, 0xBBAA, 0xDDCC, 0x5A5A -> no dout_valid, line_count unchanged, FSM back in IDLE.
REQ-036 din_valid=0 after first payload word of WC=4 packet -> err_trunc pulse 1 cycle, fr_valid=0, next valid word treated as header; reset_n=0 mid-payload -> all outputs 0 next cycle.
